// File: rtl/sram_bist_target_pkg.sv
// Shared types and write-mask helpers for the BIST memory target.
package sram_bist_target_pkg;

  typedef enum logic [0:0] {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } sram_target_state_t;

  // Helpers operate on maximum-width vectors; callers size-cast to their own widths.
  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_MASK_WIDTH = 128;
  localparam int unsigned DATA_IDX_W     = $clog2(MAX_DATA_WIDTH);
  localparam int unsigned MASK_IDX_W     = $clog2(MAX_MASK_WIDTH);

  function automatic int unsigned seg_width(input int unsigned data_width,
                                            input int unsigned mask_width);
    return data_width / mask_width;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] apply_wmask(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_MASK_WIDTH-1:0] mask,
    input int unsigned               data_width,
    input int unsigned               mask_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    int unsigned               seg;
    merged = old_word;
    seg    = seg_width(data_width, mask_width);
    for (int unsigned i = 0; i < data_width; i++) begin
      if (mask[MASK_IDX_W'(i / seg)]) merged[DATA_IDX_W'(i)] = new_word[DATA_IDX_W'(i)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_fault_overlay.sv
// Read-path stuck-at overlay: forces one bit of the read word when the address matches.
module sram_fault_overlay
  import sram_bist_target_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]         i_word,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic                          i_fault_en,
  input  logic [ADDR_WIDTH-1:0]         i_fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_fault_bit,
  input  logic                          i_fault_val,
  output logic [DATA_WIDTH-1:0]         o_word
);

  always_comb begin
    o_word = i_word;
    if (i_fault_en && (i_addr == i_fault_addr)) o_word[i_fault_bit] = i_fault_val;
  end

endmodule

// File: rtl/sram_bist_target.sv
// Synchronous SRAM responder for the BIST memory interface: clear sweep, OOB flag, counters.
// Define SRAM_BIST_TARGET_FAULT_INJECT_EN to add stuck-at fault injection on the read path.
module sram_bist_target
  import sram_bist_target_pkg::*;
#(
  parameter int unsigned MAX_ADDR   = 255,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_ADDR + 1),
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [MASK_WIDTH-1:0]         wmask,
  input  logic                          we,
  input  logic                          re,
`ifdef SRAM_BIST_TARGET_FAULT_INJECT_EN
  input  logic                          fault_en,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
  input  logic                          fault_val,
`endif
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          ready,
  output logic                          oob,
  output logic [CNT_WIDTH-1:0]          rd_count,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  // One extra bit so the range compare is never trivially constant.
  localparam logic [ADDR_WIDTH:0]   LAST_ADDR = (ADDR_WIDTH + 1)'(MAX_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(MAX_ADDR);

  sram_target_state_t     r_state;
  logic [ADDR_WIDTH-1:0]  r_ptr;
  logic [DATA_WIDTH-1:0]  r_mem [0:MAX_ADDR];
  logic [DATA_WIDTH-1:0]  r_dout;
  logic                   r_ready;
  logic                   r_oob;
  logic [CNT_WIDTH-1:0]   r_rd_count;
  logic [CNT_WIDTH-1:0]   r_wr_count;

  logic                   w_accept;
  logic                   w_rd;
  logic                   w_wr;
  logic                   w_in_range;
  logic                   w_mem_we;
  logic [ADDR_WIDTH-1:0]  w_mem_addr;
  logic [DATA_WIDTH-1:0]  w_mem_wdata;
  logic [DATA_WIDTH-1:0]  w_rd_word;
  logic [DATA_WIDTH-1:0]  w_rd_data;

  assign w_accept   = r_ready & (we | re);
  assign w_rd       = w_accept & re;
  assign w_wr       = w_accept & we;
  assign w_in_range = ({1'b0, addr} <= LAST_ADDR);
  assign w_rd_word  = w_in_range ? r_mem[addr] : '0;

`ifdef SRAM_BIST_TARGET_FAULT_INJECT_EN
  sram_fault_overlay #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fault_overlay (
    .i_word       (w_rd_word),
    .i_addr       (addr),
    .i_fault_en   (fault_en),
    .i_fault_addr (fault_addr),
    .i_fault_bit  (fault_bit),
    .i_fault_val  (fault_val),
    .o_word       (w_rd_data)
  );
`else
  assign w_rd_data = w_rd_word;
`endif

  // Single write port shared by the clear sweep and accepted in-range writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = addr;
    w_mem_wdata = '0;
    if (!rst) begin
      if (r_state == CLEAR) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_ptr;
      end else if (w_wr && w_in_range) begin
        w_mem_we    = 1'b1;
        w_mem_wdata = DATA_WIDTH'(apply_wmask(MAX_DATA_WIDTH'(w_rd_word),
                                              MAX_DATA_WIDTH'(data),
                                              MAX_MASK_WIDTH'(wmask),
                                              DATA_WIDTH, MASK_WIDTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_ptr      <= '0;
      r_dout     <= '0;
      r_ready    <= 1'b0;
      r_oob      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_ptr == PTR_LAST) begin
            r_state <= ACTIVE;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ACTIVE: begin
          if (w_rd) r_dout <= w_rd_data;
          if (w_accept && !w_in_range) r_oob <= 1'b1;
          if (w_rd && (r_rd_count != '1)) r_rd_count <= r_rd_count + 1'b1;
          if (w_wr && (r_wr_count != '1)) r_wr_count <= r_wr_count + 1'b1;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign dout     = r_dout;
  assign ready    = r_ready;
  assign oob      = r_oob;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_sram_bist_target.sv
// Self-checking bench for sram_bist_target: directed table, corner sequences, random vs model.
module tb_sram_bist_target;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  wmask;
  logic [31:0] dout;
  logic        ready, oob;
  logic [31:0] rd_count, wr_count;

  logic        b_rst, b_we, b_re;
  logic [7:0]  b_addr;
  logic [31:0] b_data;
  logic [3:0]  b_wmask;
  logic [31:0] b_dout;
  logic        b_ready, b_oob;
  logic [3:0]  b_rd_count, b_wr_count;

  logic        f_en, f_val;
  logic [7:0]  f_addr;
  logic [4:0]  f_bit;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_dout;
  int          m_rd, m_wr, m_cyc;
  logic        m_ready;

  always #5 clk = ~clk;

  sram_bist_target dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .wmask    (wmask),
    .we       (we),
    .re       (re),
`ifdef SRAM_BIST_TARGET_FAULT_INJECT_EN
    .fault_en   (f_en),
    .fault_addr (f_addr),
    .fault_bit  (f_bit),
    .fault_val  (f_val),
`endif
    .dout     (dout),
    .ready    (ready),
    .oob      (oob),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  sram_bist_target #(
    .MAX_ADDR  (200),
    .CNT_WIDTH (4)
  ) dut_b (
    .clk      (clk),
    .rst      (b_rst),
    .addr     (b_addr),
    .data     (b_data),
    .wmask    (b_wmask),
    .we       (b_we),
    .re       (b_re),
`ifdef SRAM_BIST_TARGET_FAULT_INJECT_EN
    .fault_en   (1'b0),
    .fault_addr ('0),
    .fault_bit  ('0),
    .fault_val  (1'b0),
`endif
    .dout     (b_dout),
    .ready    (b_ready),
    .oob      (b_oob),
    .rd_count (b_rd_count),
    .wr_count (b_wr_count)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp_dout;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle on the main DUT and advance the model by the rules of the block.
  task automatic drive(input logic w, input logic r, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    logic [31:0] lanes;
    we = w; re = r; addr = a; data = d; wmask = m;
    @(posedge clk);
    if (m_ready && (w || r)) begin
      lanes = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      if (r) begin
        m_dout = m_mem[a];
        m_rd++;
      end
      if (w) begin
        m_mem[a] = (m_mem[a] & ~lanes) | (d & lanes);
        m_wr++;
      end
    end
    m_cyc++;
    if (m_cyc >= 256) m_ready = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0;
    @(posedge clk);
    foreach (m_mem[i]) m_mem[i] = '0;
    m_dout = '0; m_rd = 0; m_wr = 0; m_cyc = 0; m_ready = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic sweep(output int n);
    n = 0;
    while (!ready && n < 400) begin
      drive(1'b1, 1'b1, 8'(n), 32'hFFFF_FFFF, 4'hF);
      n++;
    end
  endtask

  task automatic drive_b(input logic w, input logic r, input logic [7:0] a,
                         input logic [31:0] d);
    b_we = w; b_re = r; b_addr = a; b_data = d; b_wmask = 4'hF;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; we = 0; re = 0; addr = 0; data = 0; wmask = 0;
    b_rst = 1'b1; b_we = 0; b_re = 0; b_addr = 0; b_data = 0; b_wmask = 0;
    f_en = 0; f_val = 0; f_addr = 0; f_bit = 0;

    // Reset values and clear sweep with requests held active (must be ignored)
    do_reset();
    chk("rst_dout", dout, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_oob", {31'b0, oob}, 32'h0);
    chk("rst_rd", rd_count, 32'h0);
    chk("rst_wr", wr_count, 32'h0);
    sweep(n);
    chk("sweep_len", n, 256);
    chk("sweep_dout", dout, 32'h0);
    chk("sweep_rd", rd_count, 32'h0);
    chk("sweep_wr", wr_count, 32'h0);
    drive(1'b0, 1'b1, 8'h7F, 32'h0, 4'h0);
    chk("clear_rd_7f", dout, 32'h0);
    chk("clear_rdcnt", rd_count, 32'd1);

    // Reset in the middle of activity
    drive(1'b1, 1'b0, 8'd3, 32'hFFFF_FFFF, 4'hF);
    drive(1'b0, 1'b1, 8'd3, 32'h0, 4'h0);
    chk("pre_rst_rd3", dout, 32'hFFFF_FFFF);
    do_reset();
    chk("midrst_ready", {31'b0, ready}, 32'h0);
    chk("midrst_dout", dout, 32'h0);
    chk("midrst_rd", rd_count, 32'h0);
    chk("midrst_wr", wr_count, 32'h0);
    sweep(n);
    chk("midrst_sweep_len", n, 256);
    chk("midrst_cnt_rd", rd_count, 32'h0);
    chk("midrst_cnt_wr", wr_count, 32'h0);

    // Directed table: masked writes, collision, zero mask, boundary addresses
    tbl[0]  = '{1'b1, 1'b0, 8'd5,   32'hDEADBEEF, 4'hF, 32'h00000000, 0, 1};
    tbl[1]  = '{1'b1, 1'b0, 8'd5,   32'h11223344, 4'h5, 32'h00000000, 0, 2};
    tbl[2]  = '{1'b0, 1'b1, 8'd5,   32'h0,        4'h0, 32'hDE22BE44, 1, 2};
    tbl[3]  = '{1'b0, 1'b1, 8'd3,   32'h0,        4'h0, 32'h00000000, 2, 2};
    tbl[4]  = '{1'b1, 1'b0, 8'd9,   32'hA5A5A5A5, 4'hF, 32'h00000000, 2, 3};
    tbl[5]  = '{1'b1, 1'b1, 8'd9,   32'h00000000, 4'hF, 32'hA5A5A5A5, 3, 4};
    tbl[6]  = '{1'b0, 1'b1, 8'd9,   32'h0,        4'h0, 32'h00000000, 4, 4};
    tbl[7]  = '{1'b1, 1'b0, 8'd9,   32'hFFFFFFFF, 4'h0, 32'h00000000, 4, 5};
    tbl[8]  = '{1'b0, 1'b1, 8'd9,   32'h0,        4'h0, 32'h00000000, 5, 5};
    tbl[9]  = '{1'b0, 1'b1, 8'd5,   32'h0,        4'h0, 32'hDE22BE44, 6, 5};
    tbl[10] = '{1'b0, 1'b0, 8'd5,   32'h0,        4'h0, 32'hDE22BE44, 6, 5};
    tbl[11] = '{1'b1, 1'b0, 8'd5,   32'h00000000, 4'h8, 32'hDE22BE44, 6, 6};
    tbl[12] = '{1'b0, 1'b1, 8'd5,   32'h0,        4'h0, 32'h0022BE44, 7, 6};
    tbl[13] = '{1'b1, 1'b0, 8'd255, 32'h12345678, 4'hF, 32'h0022BE44, 7, 7};
    tbl[14] = '{1'b0, 1'b1, 8'd255, 32'h0,        4'h0, 32'h12345678, 8, 7};
    tbl[15] = '{1'b1, 1'b0, 8'd0,   32'hCAFEF00D, 4'h3, 32'h12345678, 8, 8};
    tbl[16] = '{1'b0, 1'b1, 8'd0,   32'h0,        4'h0, 32'h0000F00D, 9, 8};
    foreach (tbl[i]) begin
      drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].m);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_rd", i), rd_count, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_wr", i), wr_count, tbl[i].exp_wr);
    end
    chk("tbl_oob", {31'b0, oob}, 32'h0);

`ifdef SRAM_BIST_TARGET_FAULT_INJECT_EN
    f_en = 1'b1; f_addr = 8'd7; f_bit = 5'd4; f_val = 1'b0;
    drive(1'b1, 1'b0, 8'd7, 32'hFFFF_FFFF, 4'hF);
    drive(1'b0, 1'b1, 8'd7, 32'h0, 4'h0);
    chk("fault_rd7", dout, 32'hFFFF_FFEF);
    drive(1'b1, 1'b0, 8'd8, 32'hFFFF_FFFF, 4'hF);
    drive(1'b0, 1'b1, 8'd8, 32'h0, 4'h0);
    chk("fault_rd8", dout, 32'hFFFF_FFFF);
    f_en = 1'b0;
    drive(1'b0, 1'b1, 8'd7, 32'h0, 4'h0);
    chk("fault_off_rd7", dout, 32'hFFFF_FFFF);
`endif

    // Randomized traffic against the model, biased toward a few hot addresses
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      chk("rnd_dout", dout, m_dout);
      chk("rnd_rd", rd_count, m_rd);
      chk("rnd_wr", wr_count, m_wr);
      chk("rnd_ready", {31'b0, ready}, {31'b0, m_ready});
    end
    chk("rnd_oob", {31'b0, oob}, 32'h0);

    // Second instance: MAX_ADDR=200, 4-bit counters -- out of range and saturation
    drive_b(1'b0, 1'b0, 8'd0, 32'h0);
    chk("b_rst_oob", {31'b0, b_oob}, 32'h0);
    b_rst = 1'b0;
    n = 0;
    while (!b_ready && n < 400) begin
      drive_b(1'b1, 1'b1, 8'd0, 32'hFFFF_FFFF);
      n++;
    end
    chk("b_sweep_len", n, 201);
    drive_b(1'b1, 1'b0, 8'd10, 32'h55);
    drive_b(1'b0, 1'b1, 8'd10, 32'h0);
    chk("b_rd10", b_dout, 32'h55);
    chk("b_oob_pre", {31'b0, b_oob}, 32'h0);
    drive_b(1'b0, 1'b1, 8'd250, 32'h0);
    chk("b_oob_rd_dout", b_dout, 32'h0);
    chk("b_oob_set", {31'b0, b_oob}, 32'h1);
    chk("b_oob_rdcnt", b_rd_count, 32'd2);
    drive_b(1'b1, 1'b0, 8'd250, 32'hFFFF_FFFF);
    chk("b_oob_wrcnt", b_wr_count, 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive_b(1'b0, 1'b1, 8'd10, 32'h0);
      chk("b_oob_sticky", {31'b0, b_oob}, 32'h1);
      chk("b_rd10_again", b_dout, 32'h55);
    end
    for (int i = 0; i < 5; i++) drive_b(1'b0, 1'b1, 8'd10, 32'h0);
    chk("b_rd_sat", b_rd_count, 32'd15);
    for (int i = 0; i < 20; i++) drive_b(1'b1, 1'b0, 8'd200, 32'h77);
    chk("b_wr_sat", b_wr_count, 32'd15);
    drive_b(1'b0, 1'b1, 8'd200, 32'h0);
    chk("b_rd200", b_dout, 32'h77);
    chk("b_rd_sat_hold", b_rd_count, 32'd15);
    b_rst = 1'b1;
    drive_b(1'b0, 1'b0, 8'd0, 32'h0);
    b_rst = 1'b0;
    chk("b_rst_oob_clr", {31'b0, b_oob}, 32'h0);
    chk("b_rst_rd", b_rd_count, 32'h0);
    chk("b_rst_wr", b_wr_count, 32'h0);
    chk("b_rst_ready", {31'b0, b_ready}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bist_target.md
Name: sram_bist_target

Overview:
- Cycle-accurate synchronous SRAM responder for the far end of the BIST memory interface.
- Accepts addr/data/wmask/we/re from the BIST controller and returns dout one cycle after a read.
- Used in simulation and FPGA bring-up as the memory under test.
- Includes a post-reset clear sweep, out-of-range detection, access counters and optional stuck-at fault injection so BIST pass and fail paths can both be exercised.

Parameters:
- MAX_ADDR, 255, highest valid word address; depth = MAX_ADDR+1.
- ADDR_WIDTH, $clog2(MAX_ADDR+1), address bus width.
- DATA_WIDTH, 32, word width.
- MASK_WIDTH, 4, write-mask bits; DATA_WIDTH must be divisible by MASK_WIDTH; each mask bit covers DATA_WIDTH/MASK_WIDTH contiguous bits, LSB-first.
- CNT_WIDTH, 32, width of the access counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- addr  input  ADDR_WIDTH  word address.
- data  input  DATA_WIDTH  write data.
- wmask  input  MASK_WIDTH  per-segment write enable.
- we  input  1  write request.
- re  input  1  read request.
- dout  output  DATA_WIDTH  read data, valid the cycle after re.
- ready  output  1  high when the clear sweep is done and requests are accepted.
- oob  output  1  sticky; set by any accepted we/re with addr > MAX_ADDR.
- rd_count  output  CNT_WIDTH  accepted reads since reset.
- wr_count  output  CNT_WIDTH  accepted writes since reset.

Behaviour:
- The reset port is named rst, as on the BIST interface. Clock is clk. Reset is synchronous and active-high.
- States: CLEAR, ACTIVE.
- Reset values: state=CLEAR, sweep pointer=0, dout=0, ready=0, oob=0, rd_count=0, wr_count=0.
- CLEAR state:
  - Writes 0 to word[ptr] each cycle; ptr increments.
  - When ptr==MAX_ADDR is written, go to ACTIVE the next cycle and ready=1.
  - Sweep takes MAX_ADDR+1 cycles. we/re are ignored, dout holds 0, counters do not move.
- ACTIVE state:
  - Request accepted iff ready and (we or re).
  - Write: for each i with wmask[i]=1, segment i of word[addr] takes data segment i. Unmasked segments are unchanged. wmask=0 with we=1 still counts as a write.
  - Read: dout <= word[addr] at the next edge (1-cycle latency, matches BIST compare of dout against prev_expected).
  - re=0: dout holds its previous value.
  - we and re together at the same addr: read returns pre-write contents (read-before-write); both counters increment.
  - addr > MAX_ADDR: write dropped; read returns all-zeros; oob set and held until rst; the access is still counted.
- Counters saturate at all-ones; no wrap.
- rst asserted mid-operation (any state): return to CLEAR and restart the full sweep. The array is re-cleared.
- No X is ever driven on dout.

Optional Feature:
- Macro: SRAM_BIST_TARGET_FAULT_INJECT_EN.
- With the macro defined, extra inputs are present:
  - fault_en (1)
  - fault_addr (ADDR_WIDTH)
  - fault_bit ($clog2(DATA_WIDTH))
  - fault_val (1)
- Fault application:
  - When fault_en=1, any read of fault_addr returns dout with bit fault_bit forced to fault_val (stuck-at).
  - Writes store normally; the fault applies on the read path only.
  - Fault inputs are sampled in the same cycle as re.
- Without the macro: ports are absent and reads are never altered.

Decomposition:
- Package sram_bist_target_pkg:
  - sram_target_state_t enum {CLEAR, ACTIVE}.
  - Function seg_width(DATA_WIDTH, MASK_WIDTH).
  - Function apply_wmask(old, new, mask) returning the merged word.
- Sub-module sram_fault_overlay:
  - Combinational bit-force on the read path, instantiated only under the macro.
- Array, FSM and counters stay in the top module.

Test Plan:
- Clear sweep: rst 1 cycle with MAX_ADDR=255 -> ready=0 for exactly 256 cycles then 1; read of addr 0x7F returns 0x00000000.
- Masked write: write 0xDEADBEEF wmask=4'b1111 to addr 5, then 0x11223344 wmask=4'b0101 -> read addr 5 next cycle gives dout=0xDE22BE44 one cycle after re; wr_count=2, rd_count=1.
- Collision: word[9]=0xA5A5A5A5; we=1, re=1, addr 9, data 0x0 -> dout=0xA5A5A5A5; following read gives 0x00000000.
- Out of range: MAX_ADDR=200, re at addr 250 -> dout=0, oob=1 and stays 1 through 10 further valid accesses until rst.
- Reset mid-op: rst pulsed during ACTIVE after writing 0xFFFFFFFF to addr 3 -> ready drops, 256-cycle sweep, read addr 3 = 0, counters=0.
- Fault (macro on): fault_en=1, fault_addr=7, fault_bit=4, fault_val=0; write 0xFFFFFFFF to 7, read -> dout=0xFFFFFFEF; full BIST run against the block ends with fail=1 and fail_addr=7. Without the fault, the full BIST run ends with done=1, fail=0.
